// File: rtl/l2_pmem_responder.sv
// Fixed-latency line memory on the pmem side of the L2.
// One 128-bit line transaction at a time, with a turnaround cycle after each response.
module l2_pmem_responder #(
   parameter int LATENCY   = 8,
   parameter int LINE_BITS = 8
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         pmem_read,
   input  logic         pmem_write,
   input  logic [15:0]  pmem_address,
   input  logic [127:0] pmem_wdata,
   output logic         pmem_resp,
   output logic [127:0] pmem_rdata,
   output logic         busy,
   output logic         prot_err
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_WAIT,
      S_RESP,
      S_TURN
   } state_t;

   state_t                 r_state;
   state_t                 w_next;
   logic [7:0]             r_cnt;
   logic [7:0]             w_cnt_next;
   logic                   r_op_wr;
   logic [LINE_BITS-1:0]   r_idx;
   logic [127:0]           r_wdata;
   logic [127:0]           r_rdata;
   logic                   r_prot;
   logic [127:0]           r_mem [2**LINE_BITS];

   logic                   w_req;
   logic                   w_accept;
   logic                   w_enter_resp;
   logic                   w_op_wr;
   logic [LINE_BITS-1:0]   w_idx;
   logic [127:0]           w_wdata;
   logic                   w_unused;

   assign w_req    = pmem_read | pmem_write;
   assign w_accept = (r_state == S_IDLE) && w_req;
   assign w_unused = ^pmem_address;

   // With LATENCY=1 the memory access happens on the accept edge itself,
   // so the live request is used instead of the (not yet loaded) capture.
   assign w_op_wr = (r_state == S_IDLE) ? pmem_write : r_op_wr;
   assign w_idx   = (r_state == S_IDLE) ?
                    pmem_address[LINE_BITS+3:4] : r_idx;
   assign w_wdata = (r_state == S_IDLE) ? pmem_wdata : r_wdata;

   assign w_enter_resp = (w_next == S_RESP) && (r_state != S_RESP);

   always_comb begin
      w_next     = r_state;
      w_cnt_next = r_cnt;
      unique case (r_state)
         S_IDLE: begin
            if (w_req) begin
               w_cnt_next = 8'(LATENCY - 1);
               w_next     = (LATENCY == 1) ? S_RESP : S_WAIT;
            end
         end
         S_WAIT: begin
            w_cnt_next = r_cnt - 8'd1;
            if (r_cnt <= 8'd1) begin
               w_next = S_RESP;
            end
         end
         S_RESP: begin
            w_next = S_TURN;
         end
         S_TURN: begin
            w_next = S_IDLE;
         end
         default: begin
            w_next = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state <= S_IDLE;
         r_cnt   <= '0;
      end else begin
         r_state <= w_next;
         r_cnt   <= w_cnt_next;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_op_wr <= 1'b0;
         r_idx   <= '0;
         r_wdata <= '0;
      end else if (w_accept) begin
         r_op_wr <= pmem_write;
         r_idx   <= pmem_address[LINE_BITS+3:4];
         r_wdata <= pmem_wdata;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_prot <= 1'b0;
      end else if (w_accept && pmem_read && pmem_write) begin
         r_prot <= 1'b1;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_rdata <= '0;
      end else if (w_enter_resp && !w_op_wr) begin
         r_rdata <= r_mem[w_idx];
      end
   end

   // Storage carries no reset; a reset before RESP drops the write.
   always_ff @(posedge clk) begin
      if (w_enter_resp && w_op_wr) begin
         r_mem[w_idx] <= w_wdata;
      end
   end

   assign pmem_resp  = (r_state == S_RESP);
   assign busy       = (r_state != S_IDLE);
   assign pmem_rdata = r_rdata;
   assign prot_err   = r_prot;

endmodule

// File: tb/tb_l2_pmem_responder.sv
// Bench for l2_pmem_responder: LATENCY 8, 1 and 3 instances.
// Vector table plus hand sequences, checked through a scoreboard queue.
module tb_l2_pmem_responder;

   logic         clk = 1'b0;
   logic         reset;
   logic         rd    [3];
   logic         wr    [3];
   logic [15:0]  addr  [3];
   logic [127:0] wdata [3];
   logic         resp  [3];
   logic [127:0] rdata [3];
   logic         busy  [3];
   logic         perr  [3];

   int lats [3] = '{8, 1, 3};

   int checks   = 0;
   int failures = 0;

   typedef struct {
      int           lat;
      logic [127:0] data;
   } sb_t;
   sb_t sb_q[$];

   typedef struct {
      logic         r;
      logic         w;
      logic [15:0]  a;
      logic [127:0] wd;
      logic [127:0] exp;
   } vec_t;
   vec_t tbl [6];

   localparam logic [127:0] D1 = 128'h0123_4567_89AB_CDEF_0011_2233_4455_6677;
   localparam logic [127:0] D2 = 128'hDEAD_BEEF_0BAD_F00D_1357_9BDF_2468_ACE0;
   localparam logic [127:0] D3 = 128'hCAFE_BABE_FEED_FACE_8765_4321_0F0F_F0F0;
   localparam logic [127:0] DA = {16{8'hA5}};
   localparam logic [127:0] DX = {8{16'h1111}};

   always #5 clk = ~clk;

   l2_pmem_responder #(.LATENCY(8), .LINE_BITS(8)) u_l8 (
      .clk(clk), .reset(reset),
      .pmem_read(rd[0]), .pmem_write(wr[0]),
      .pmem_address(addr[0]), .pmem_wdata(wdata[0]),
      .pmem_resp(resp[0]), .pmem_rdata(rdata[0]),
      .busy(busy[0]), .prot_err(perr[0])
   );

   l2_pmem_responder #(.LATENCY(1), .LINE_BITS(8)) u_l1 (
      .clk(clk), .reset(reset),
      .pmem_read(rd[1]), .pmem_write(wr[1]),
      .pmem_address(addr[1]), .pmem_wdata(wdata[1]),
      .pmem_resp(resp[1]), .pmem_rdata(rdata[1]),
      .busy(busy[1]), .prot_err(perr[1])
   );

   l2_pmem_responder #(.LATENCY(3), .LINE_BITS(8)) u_l3 (
      .clk(clk), .reset(reset),
      .pmem_read(rd[2]), .pmem_write(wr[2]),
      .pmem_address(addr[2]), .pmem_wdata(wdata[2]),
      .pmem_resp(resp[2]), .pmem_rdata(rdata[2]),
      .busy(busy[2]), .prot_err(perr[2])
   );

   task automatic check(input string nm, input logic [127:0] act,
                        input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s got=%h want=%h", nm, act, exp);
      end
   endtask

   // Called just after a negedge with the DUT idle; returns at a negedge.
   task automatic run_txn(input int d, input logic r, input logic w,
                          input logic [15:0] a, input logic [127:0] wd,
                          input logic [127:0] exp,
                          input int drop_at, input int mut_at);
      sb_t e;
      int  n;
      bit  seen;
      e.lat  = lats[d];
      e.data = exp;
      sb_q.push_back(e);
      rd[d]    = r;
      wr[d]    = w;
      addr[d]  = a;
      wdata[d] = wd;
      seen = 0;
      for (n = 1; n <= 300; n++) begin
         @(negedge clk);
         if (resp[d]) begin
            seen = 1;
            break;
         end
         if (n == drop_at) begin
            rd[d] = 1'b0;
            wr[d] = 1'b0;
         end
         if (n == mut_at) begin
            addr[d]  = 16'h4560;
            wdata[d] = '1;
         end
      end
      rd[d] = 1'b0;
      wr[d] = 1'b0;
      e = sb_q.pop_front();
      if (!seen) begin
         checks++;
         failures++;
         $display("FAIL resp_timeout dut=%0d", d);
         return;
      end
      check("latency", 128'(n), 128'(e.lat));
      check("rdata", rdata[d], e.data);
      @(negedge clk);
      check("turn_resp_busy", {126'd0, resp[d], busy[d]}, 128'b01);
      @(negedge clk);
      check("idle_busy", {127'd0, busy[d]}, 128'd0);
   endtask

   initial begin
      int first_n;
      int second_n;
      int pulses;
      int n;

      tbl[0] = '{1'b0, 1'b1, 16'h1230, D1, 128'd0};
      tbl[1] = '{1'b1, 1'b0, 16'h1238, '0, D1};
      tbl[2] = '{1'b1, 1'b0, 16'h4560, '0, 128'd0};
      tbl[3] = '{1'b0, 1'b1, 16'h0050, D2, 128'd0};
      tbl[4] = '{1'b1, 1'b0, 16'h1050, '0, D2};
      tbl[5] = '{1'b1, 1'b0, 16'hFFF0, '0, 128'd0};

      for (int i = 0; i < 3; i++) begin
         rd[i]    = 1'b0;
         wr[i]    = 1'b0;
         addr[i]  = '0;
         wdata[i] = '0;
      end
      reset = 1'b1;
      repeat (3) @(negedge clk);
      check("reset_outs", {124'd0, resp[0], busy[0], perr[0], |rdata[0]},
            128'd0);
      reset = 1'b0;
      @(negedge clk);

      for (int i = 0; i < 6; i++) begin
         run_txn(0, tbl[i].r, tbl[i].w, tbl[i].a, tbl[i].wd,
                 tbl[i].exp, 0, 0);
      end

      // request dropped after two cycles still completes on time
      run_txn(0, 1'b1, 1'b0, 16'h1230, '0, D1, 2, 0);

      // read held through TURN: re-accepted only from IDLE
      rd[0]   = 1'b1;
      addr[0] = 16'h1230;
      first_n  = 0;
      second_n = 0;
      pulses   = 0;
      for (n = 1; n <= 2 * lats[0] + 3; n++) begin
         @(negedge clk);
         if (resp[0]) begin
            pulses++;
            if (pulses == 1) first_n = n;
            else second_n = n;
            check("held_rdata", rdata[0], D1);
         end
         if (n == lats[0] + 2) begin
            check("held_idle_gap", {127'd0, busy[0]}, 128'd0);
         end
      end
      rd[0] = 1'b0;
      check("held_pulses", 128'(pulses), 128'd2);
      check("held_first", 128'(first_n), 128'(lats[0]));
      check("held_second", 128'(second_n), 128'(2 * lats[0] + 2));
      n = 0;
      while (busy[0] && n < 50) begin
         @(negedge clk);
         n++;
      end
      check("held_drain", {127'd0, busy[0]}, 128'd0);

      // inputs changed during WAIT must not affect the captured write
      run_txn(0, 1'b0, 1'b1, 16'h1230, D3, D1, 0, 2);
      run_txn(0, 1'b1, 1'b0, 16'h1230, '0, D3, 0, 0);
      run_txn(0, 1'b1, 1'b0, 16'h4560, '0, 128'd0, 0, 0);

      // simultaneous read+write acts as a write and sets prot_err
      check("prot_clear", {127'd0, perr[0]}, 128'd0);
      run_txn(0, 1'b1, 1'b1, 16'h0040, DA, 128'd0, 0, 0);
      check("prot_set", {127'd0, perr[0]}, 128'd1);
      run_txn(0, 1'b1, 1'b0, 16'h0040, '0, DA, 0, 0);
      check("prot_sticky", {127'd0, perr[0]}, 128'd1);

      // reset while a write is in WAIT abandons it
      wr[0]    = 1'b1;
      addr[0]  = 16'h0040;
      wdata[0] = DX;
      repeat (3) @(negedge clk);
      check("pre_reset_busy", {127'd0, busy[0]}, 128'd1);
      #2 reset = 1'b1;
      #1;
      check("async_reset", {124'd0, resp[0], busy[0], perr[0], |rdata[0]},
            128'd0);
      wr[0] = 1'b0;
      @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      run_txn(0, 1'b1, 1'b0, 16'h0040, '0, DA, 0, 0);

      // latency 1 and 3 builds
      run_txn(1, 1'b0, 1'b1, 16'h0100, D2, 128'd0, 0, 0);
      run_txn(1, 1'b1, 1'b0, 16'h0100, '0, D2, 0, 0);
      run_txn(2, 1'b0, 1'b1, 16'h0100, D3, 128'd0, 0, 0);
      run_txn(2, 1'b1, 1'b0, 16'h0100, '0, D3, 0, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
